// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin arbiter that shares one DMA engine among NUM_REQ
// requesters, latching the winner's descriptor and reporting done/timeout.
module dma_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_amt,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rom,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_ram,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_err,
    output logic                          dma_start,
    output logic [ADDR_WIDTH-1:0]         dma_data_amt,
    output logic [ADDR_WIDTH-1:0]         dma_starting_rom,
    output logic [ADDR_WIDTH-1:0]         dma_starting_ram,
    input  logic                          dma_done,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      win_q, win_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [NUM_REQ-1:0]    err_q, err_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] amt_q, amt_d;
    logic [ADDR_WIDTH-1:0] rom_q, rom_d;
    logic [ADDR_WIDTH-1:0] ram_q, ram_d;

    logic [ADDR_WIDTH-1:0] amt_a [NUM_REQ];
    logic [ADDR_WIDTH-1:0] rom_a [NUM_REQ];
    logic [ADDR_WIDTH-1:0] ram_a [NUM_REQ];

    logic                  found;
    logic [IDX_W-1:0]      pick;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [NUM_REQ-1:0]    win_oh;

    always_comb begin : unpack
        for (int i = 0; i < NUM_REQ; i++) begin
            amt_a[i] = req_amt[i*ADDR_WIDTH +: ADDR_WIDTH];
            rom_a[i] = req_rom[i*ADDR_WIDTH +: ADDR_WIDTH];
            ram_a[i] = req_ram[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Search ascends from ptr and wraps, so the first hit is the RR winner.
    always_comb begin : rr_pick
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[IDX_W'(idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    assign pick_oh = NUM_REQ'(1) << pick;
    assign win_oh  = NUM_REQ'(1) << win_q;

    always_comb begin : next_state
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        start_d = 1'b0;
        amt_d   = amt_q;
        rom_d   = rom_q;
        ram_d   = ram_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_LAUNCH;
                    win_d   = pick;
                    grant_d = pick_oh;
                    amt_d   = amt_a[pick];
                    rom_d   = rom_a[pick];
                    ram_d   = ram_a[pick];
                    start_d = (amt_a[pick] != '0);
                end
            end
            S_LAUNCH: begin
                if (amt_q != '0) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_RELEASE;
                    grant_d = '0;
                    done_d  = win_oh;
                end
            end
            S_WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (dma_done) begin
                    state_d = S_RELEASE;
                    grant_d = '0;
                    done_d  = win_oh;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RELEASE;
                    grant_d = '0;
                    err_d   = win_oh;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                ptr_d   = (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            amt_q   <= '0;
            rom_q   <= '0;
            ram_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            amt_q   <= amt_d;
            rom_q   <= rom_d;
            ram_q   <= ram_d;
        end
    end

    assign grant            = grant_q;
    assign req_done         = done_q;
    assign req_err          = err_q;
    assign dma_start        = start_q;
    assign busy             = busy_q;
    assign dma_data_amt     = amt_q;
    assign dma_starting_rom = rom_q;
    assign dma_starting_ram = ram_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: round-robin order, latching, zero-length,
// timeout, ignored dma_done and asynchronous reset mid-transfer.
module tb_dma_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_amt, req_rom, req_ram;
    logic [3:0]  grant, req_done, req_err;
    logic        dma_start, dma_done, busy;
    logic [3:0]  dma_data_amt, dma_starting_rom, dma_starting_ram;

    logic [3:0] amt_a [4];
    logic [3:0] rom_a [4];
    logic [3:0] ram_a [4];

    int checks = 0;
    int errors = 0;

    assign req_amt = {amt_a[3], amt_a[2], amt_a[1], amt_a[0]};
    assign req_rom = {rom_a[3], rom_a[2], rom_a[1], rom_a[0]};
    assign req_ram = {ram_a[3], ram_a[2], ram_a[1], ram_a[0]};

    dma_arbiter #(
        .NUM_REQ(4),
        .ADDR_WIDTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_amt(req_amt),
        .req_rom(req_rom),
        .req_ram(req_ram),
        .grant(grant),
        .req_done(req_done),
        .req_err(req_err),
        .dma_start(dma_start),
        .dma_data_amt(dma_data_amt),
        .dma_starting_rom(dma_starting_rom),
        .dma_starting_ram(dma_starting_ram),
        .dma_done(dma_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic set_desc(input int i, input logic [3:0] a,
                            input logic [3:0] r, input logic [3:0] m);
        amt_a[i] = a;
        rom_a[i] = r;
        ram_a[i] = m;
    endtask

    // One full grant/launch/complete handshake; engine answers after lat cycles.
    task automatic serve(input logic [3:0] exp_g, input int lat,
                         input string tag);
        int n;
        n = 0;
        while (grant === 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " grant"}, grant, exp_g);
        chkb({tag, " start"}, dma_start, 1'b1);
        tick();
        repeat (lat - 1) tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk({tag, " done"}, req_done, exp_g);
        chk({tag, " grant_rel"}, grant, 4'b0);
        tick();
        chkb({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        req      = 4'b0;
        dma_done = 1'b0;
        for (int i = 0; i < 4; i++) set_desc(i, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        chk("rst grant", grant, 4'b0);
        chk("rst done", req_done, 4'b0);
        chk("rst err", req_err, 4'b0);
        chkb("rst start", dma_start, 1'b0);
        chkb("rst busy", busy, 1'b0);
        chk("rst amt", dma_data_amt, 4'd0);
        reset = 1'b1;

        // Round robin with all requesters held
        for (int i = 0; i < 4; i++) set_desc(i, 4'd1, 4'(i), 4'(i));
        req = 4'b1111;
        serve(4'b0001, 2, "rr0");
        serve(4'b0010, 2, "rr1");
        serve(4'b0100, 2, "rr2");
        serve(4'b1000, 2, "rr3");
        serve(4'b0001, 2, "rr4");
        req = 4'b0;

        // Single transfer 5/3/9, dma_done six cycles after dma_start
        set_desc(1, 4'd5, 4'd3, 4'd9);
        req = 4'b0010;
        tick();
        chk("t1 grant", grant, 4'b0010);
        chkb("t1 start", dma_start, 1'b1);
        chk("t1 amt", dma_data_amt, 4'd5);
        chk("t1 rom", dma_starting_rom, 4'd3);
        chk("t1 ram", dma_starting_ram, 4'd9);
        chkb("t1 busy", busy, 1'b1);
        set_desc(1, 4'd15, 4'd15, 4'd15);
        tick();
        chkb("t1 start1", dma_start, 1'b0);
        chk("t1 amt_hold", dma_data_amt, 4'd5);
        repeat (5) begin
            tick();
            chkb("t1 no_start", dma_start, 1'b0);
            chk("t1 no_done", req_done, 4'b0);
        end
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        req      = 4'b0;
        chk("t1 done", req_done, 4'b0010);
        chk("t1 grant_rel", grant, 4'b0);
        chkb("t1 busy_rel", busy, 1'b1);
        chk("t1 rom_hold", dma_starting_rom, 4'd3);
        tick();
        chk("t1 done_pulse", req_done, 4'b0);
        chkb("t1 idle", busy, 1'b0);

        // dma_done in IDLE and LAUNCH ignored; req drop mid-transfer ignored
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chkb("ign idle busy", busy, 1'b0);
        chk("ign idle done", req_done, 4'b0);
        set_desc(2, 4'd4, 4'd1, 4'd2);
        req = 4'b0100;
        tick();
        chk("ign grant", grant, 4'b0100);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk("ign launch done", req_done, 4'b0);
        chkb("ign launch busy", busy, 1'b1);
        req = 4'b0;
        tick();
        chk("drop grant", grant, 4'b0100);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk("drop done", req_done, 4'b0100);
        tick();
        chkb("drop idle", busy, 1'b0);

        // Zero-length descriptor completes without dma_start
        set_desc(2, 4'd0, 4'd1, 4'd2);
        req = 4'b0100;
        tick();
        chk("z grant", grant, 4'b0100);
        chkb("z start", dma_start, 1'b0);
        tick();
        chk("z done", req_done, 4'b0100);
        chkb("z start2", dma_start, 1'b0);
        chk("z grant_rel", grant, 4'b0);
        req = 4'b0;
        tick();
        chkb("z idle", busy, 1'b0);

        // Timeout after 16 WAIT cycles, then next requester is served
        set_desc(3, 4'd2, 4'd4, 4'd6);
        set_desc(0, 4'd1, 4'd1, 4'd1);
        req = 4'b1001;
        tick();
        chk("to grant", grant, 4'b1000);
        tick();
        repeat (15) begin
            tick();
            chk("to no_err", req_err, 4'b0);
            chk("to held", grant, 4'b1000);
        end
        tick();
        chk("to err", req_err, 4'b1000);
        chk("to no_done", req_done, 4'b0);
        chk("to grant_rel", grant, 4'b0);
        req = 4'b0001;
        tick();
        chk("to err_pulse", req_err, 4'b0);
        tick();
        chk("to next", grant, 4'b0001);
        tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk("to next_done", req_done, 4'b0001);
        req = 4'b0;
        tick();

        // Asynchronous reset during WAIT
        set_desc(0, 4'd3, 4'd6, 4'd7);
        req = 4'b0001;
        tick();
        tick();
        tick();
        chkb("ar busy", busy, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        chk("ar grant", grant, 4'b0);
        chkb("ar busy0", busy, 1'b0);
        chk("ar amt", dma_data_amt, 4'd0);
        chk("ar rom", dma_starting_rom, 4'd0);
        chk("ar ram", dma_starting_ram, 4'd0);
        dma_done = 1'b1;
        tick();
        chk("ar no_done", req_done, 4'b0);
        chk("ar no_err", req_err, 4'b0);
        dma_done = 1'b0;
        req      = 4'b1001;
        reset    = 1'b1;
        tick();
        chk("ar first", grant, 4'b0001);
        chk("ar no_done2", req_done, 4'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
